stream_fifo: RTL
================

// Module: stream_fifo
// PURPOSE
//  Synchronous single-clock word FIFO feeding the core's MMIO FIFO read port (fifo_din/fifo_re/fifo_count).
//  Host-side logic pushes 32-bit words; the core pops one word per lw from the FIFO data address.
//  Standard (non-FWFT) read mode: data appears one cycle after rd_en, qualified by valid.
//  Drop-in replacement for the vendor FIFO IP, plus an occupancy count for fifo_count.
// PARAMETERS
//  DATA_W      32  word width
//  DEPTH_LOG2  4   log2 of entry count (DEPTH = 16); legal range 1..12
// PORTS
//  clk        in   1           clock; all logic on rising edge
//  reset      in   1           synchronous, active-high reset
//  din        in   DATA_W      write data
//  wr_en      in   1           push request
//  rd_en      in   1           pop request
//  dout       out  DATA_W      read data, registered
//  valid      out  1           dout carries a freshly popped word this cycle
//  full       out  1           DEPTH entries held
//  empty      out  1           zero entries held
//  count      out  32          entries held, zero-extended (drives core fifo_count)
//  overflow   out  1           sticky: push dropped (STREAM_FIFO_ERR_EN only)
//  underflow  out  1           sticky: pop on empty (STREAM_FIFO_ERR_EN only)
// BEHAVIOUR
//  - Reset: dout=0, valid=0, empty=1, full=0, count=0, pointers=0, overflow/underflow=0; RAM contents not cleared.
//  - Reset mid-operation discards all entries; the cycle after reset deasserts behaves as freshly reset.
//  - Pointers wr_ptr/rd_ptr are DEPTH_LOG2+1 bits; index = low bits; wrap is natural modulo 2*DEPTH.
//  - Push accepted iff wr_en && !full (full sampled before this edge); a simultaneous pop does NOT free a slot.
//  - Pop accepted iff rd_en && !empty (empty sampled before this edge); a simultaneous push does NOT satisfy it.
//  - Accepted pop: dout <= mem[rd_ptr], rd_ptr++, valid=1 the next cycle; otherwise valid=0, dout holds last value.
//  - Latency: word pushed at edge N is poppable at edge N+1 (empty deasserts after edge N); dout at N+2 when popped at N+1.
//  - count updates the same edge: +1 push only, -1 pop only, unchanged for both or neither.
//  - full = (count==DEPTH), empty = (count==0), both registered, never asserted together.
//  - Dropped push and rejected pop change no pointer, count, or data.
// CONFIGURATION
//  - `STREAM_FIFO_ERR_EN defined: overflow sets on wr_en&&full, underflow sets on rd_en&&empty;
//    both sticky, cleared only by reset.
//  - Not defined: overflow and underflow tied to 0, no flag registers built.
// STRUCTURE
//  - stream_fifo_pkg: STREAM_FIFO_DATA_W=32, STREAM_FIFO_DEPTH_LOG2=4 defaults, typedef fifo_word_t.
//  - Sub-module stream_fifo_ram: simple dual-port RAM, one write port, one registered read port
//    (read enable gated by accepted pop); infers distributed/block RAM.
//  - Top holds pointers, count, flags, and the optional error logic.
// TESTING
//  - Push deadbeef, abadcafe, 34343434, a5a5a5a5 on 4 consecutive cycles, then 3 pops -> dout sequence
//    deadbeef/abadcafe/34343434 with valid one cycle after each rd_en, count 4->1, empty=0.
//  - Push 17 words 0..16 back-to-back -> full=1 after the 16th, count=16, 17th dropped; with ERR_EN overflow=1;
//    16 pops return 0..15, empty=1.
//  - rd_en on empty after reset -> valid=0, dout=0, count=0; with ERR_EN underflow=1, without it underflow=0.
//  - Count=5, wr_en&rd_en together for 3 cycles -> count stays 5, order preserved; at count=16 simultaneous
//    push+pop -> pop accepted, push dropped, count=15.
//  - 40 interleaved push/pop of incrementing words (pointer wrap twice) -> dout strictly incrementing, no loss.
//  - Assert reset with count=9 for one cycle -> next cycle count=0, empty=1, valid=0, flags cleared.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: shared defaults and word type for the stream FIFO
//  STREAM_FIFO_DATA_W      default word width
//  STREAM_FIFO_DEPTH_LOG2  default log2 of entry count
//  fifo_word_t             one FIFO word at the default width
package stream_fifo_pkg;
    localparam int STREAM_FIFO_DATA_W     = 32;
    localparam int STREAM_FIFO_DEPTH_LOG2 = 4;
    typedef logic [STREAM_FIFO_DATA_W-1:0] fifo_word_t;
endpackage

// File: rtl/stream_fifo_if.sv
// stream_fifo_if: push/pop bus between host logic (master) and the FIFO (slave)
//  din/wr_en/rd_en            master -> slave
//  dout/valid/full/empty/count/overflow/underflow  slave -> master
interface stream_fifo_if
    import stream_fifo_pkg::*;
#(
    parameter int DATA_W = STREAM_FIFO_DATA_W
);
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              full;
    logic              empty;
    logic [31:0]       count;
    logic              overflow;
    logic              underflow;

    modport master (
        output din, wr_en, rd_en,
        input  dout, valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/stream_fifo_ram.sv
// stream_fifo_ram: simple dual-port RAM, one write port and one registered read port
//  clk, reset          clock; reset clears only the read register, never the array
//  we, waddr, wdata    write port
//  re, raddr, rdata    read port; rdata updates one edge after re, holds otherwise
module stream_fifo_ram
    import stream_fifo_pkg::*;
#(
    parameter int DATA_W = STREAM_FIFO_DATA_W,
    parameter int ADDR_W = STREAM_FIFO_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk)
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: single-clock standard-read word FIFO with occupancy count
//  clk, reset  clock and synchronous active-high reset
//  bus         stream_fifo_if.slave: din/wr_en/rd_en in; dout/valid/full/empty/count/overflow/underflow out
//  Define STREAM_FIFO_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_W     = STREAM_FIFO_DATA_W,
    parameter int DEPTH_LOG2 = STREAM_FIFO_DEPTH_LOG2
) (
    input logic          clk,
    input logic          reset,
    stream_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2:0] ptr_t;

    ptr_t wr_ptr, rd_ptr, wr_nxt, rd_nxt, used, used_nxt;
    logic full, empty, valid, wr_ok, rd_ok;
    logic [DATA_W-1:0] dout;

    // full/empty are the pre-edge flags, so a same-cycle pop never makes room
    // for a push and a same-cycle push never satisfies a pop.
    assign wr_ok    = bus.wr_en && !full;
    assign rd_ok    = bus.rd_en && !empty;
    assign wr_nxt   = wr_ptr + ptr_t'(wr_ok);
    assign rd_nxt   = rd_ptr + ptr_t'(rd_ok);
    // The extra pointer bit makes the difference the exact occupancy, 0..DEPTH.
    assign used     = wr_ptr - rd_ptr;
    assign used_nxt = wr_nxt - rd_nxt;

    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            valid  <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            full   <= used_nxt == ptr_t'(DEPTH);
            empty  <= used_nxt == '0;
            valid  <= rd_ok;
        end

    stream_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ok),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (bus.din),
        .re    (rd_ok),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (dout)
    );

    assign bus.dout  = dout;
    assign bus.valid = valid;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = 32'(used);

`ifdef STREAM_FIFO_ERR_EN
    logic overflow, underflow;

    always_ff @(posedge clk)
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  || (bus.wr_en && full);
            underflow <= underflow || (bus.rd_en && empty);
        end

    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule
